// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the MEM pipeline stage
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam int TIMEOUT_CYCLES_DEFAULT = 64;
    localparam int REG_IDX_W = 5;

endpackage

// File: rtl/memwb_reg.sv
// rtl/memwb_reg.sv - MEM/WB pipeline register with load, bubble and reset controls
module memwb_reg
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 bubble,
    input  logic                 reg_write,
    input  logic                 mem_to_reg,
    input  logic [REG_IDX_W-1:0] reg_dst,
    input  logic [31:0]          read_data,
    input  logic [31:0]          alu_result,
    output logic                 WB_RegWrite,
    output logic                 WB_MemtoReg,
    output logic [REG_IDX_W-1:0] WB_RegDst,
    output logic [31:0]          WB_ReadData,
    output logic [31:0]          WB_ALUResult
);

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            WB_RegWrite  <= 1'b0;
            WB_MemtoReg  <= 1'b0;
            WB_RegDst    <= '0;
            WB_ReadData  <= '0;
            WB_ALUResult <= '0;
        end else if (load) begin
            WB_RegWrite  <= reg_write;
            WB_MemtoReg  <= mem_to_reg;
            WB_RegDst    <= reg_dst;
            WB_ReadData  <= read_data;
            WB_ALUResult <= alu_result;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-memory handshake, stall and MEM/WB register
// Optional wait timeout with sticky dmem_err is enabled by defining DMEM_TIMEOUT_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MEM_MemRead,
    input  logic                 MEM_MemWrite,
    input  logic                 MEM_MemtoReg,
    input  logic                 MEM_RegWrite,
    input  logic [REG_IDX_W-1:0] MEM_RegDst,
    input  logic [31:0]          MEM_ALUResult,
    input  logic [31:0]          MEM_ReadData2,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [31:0]          dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [31:0]          dmem_rdata,
    output logic                 MEM_Stall,
    output logic                 WB_RegWrite,
    output logic                 WB_MemtoReg,
    output logic [REG_IDX_W-1:0] WB_RegDst,
    output logic [31:0]          WB_ReadData,
    output logic [31:0]          WB_ALUResult,
    output logic                 dmem_err
);

    mem_state_t  state;
    logic        op;
    logic        timeout_hit;
    logic [31:0] load_data;

    assign op         = MEM_MemRead | MEM_MemWrite;
    assign dmem_req   = !rst & op;
    assign dmem_we    = MEM_MemWrite & !MEM_MemRead;
    assign dmem_addr  = MEM_ALUResult;
    assign dmem_wdata = MEM_ReadData2;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // The counter covers every stalled cycle, so the stall lasts exactly TIMEOUT_CYCLES.
    assign timeout_hit = (state == WAIT) & dmem_req & !dmem_ack
                       & (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign dmem_err    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
            if (MEM_Stall) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign dmem_err    = 1'b0;
`endif

    assign MEM_Stall = dmem_req & !dmem_ack & !timeout_hit;
    assign load_data = (MEM_MemRead & dmem_ack) ? dmem_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (op && !dmem_ack) state <= WAIT;
                WAIT: if (dmem_ack || timeout_hit) state <= IDLE;
            endcase
        end
    end

    memwb_reg u_memwb_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (!MEM_Stall && !timeout_hit),
        .bubble       (MEM_Stall || timeout_hit),
        .reg_write    (MEM_RegWrite),
        .mem_to_reg   (MEM_MemtoReg),
        .reg_dst      (MEM_RegDst),
        .read_data    (load_data),
        .alu_result   (MEM_ALUResult),
        .WB_RegWrite  (WB_RegWrite),
        .WB_MemtoReg  (WB_MemtoReg),
        .WB_RegDst    (WB_RegDst),
        .WB_ReadData  (WB_ReadData),
        .WB_ALUResult (WB_ALUResult)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite;
    logic [4:0]  MEM_RegDst;
    logic [31:0] MEM_ALUResult, MEM_ReadData2;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        MEM_Stall, WB_RegWrite, WB_MemtoReg, dmem_err;
    logic [4:0]  WB_RegDst;
    logic [31:0] WB_ReadData, WB_ALUResult;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_MemtoReg(MEM_MemtoReg), .MEM_RegWrite(MEM_RegWrite),
        .MEM_RegDst(MEM_RegDst), .MEM_ALUResult(MEM_ALUResult),
        .MEM_ReadData2(MEM_ReadData2),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .MEM_Stall(MEM_Stall),
        .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
        .WB_RegDst(WB_RegDst), .WB_ReadData(WB_ReadData),
        .WB_ALUResult(WB_ALUResult), .dmem_err(dmem_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_wb(input string tag, input logic rw, input logic mtr,
                            input logic [4:0] dst, input logic [31:0] rdat,
                            input logic [31:0] alu);
        check({tag, ".RegWrite"},  {31'b0, WB_RegWrite}, {31'b0, rw});
        check({tag, ".MemtoReg"},  {31'b0, WB_MemtoReg}, {31'b0, mtr});
        check({tag, ".RegDst"},    {27'b0, WB_RegDst},   {27'b0, dst});
        check({tag, ".ReadData"},  WB_ReadData,  rdat);
        check({tag, ".ALUResult"}, WB_ALUResult, alu);
    endtask

    // Presents one instruction, answers with an ack after lat cycles, and checks
    // every cycle against what the stage must do. Call shortly after a rising edge.
    task automatic run_instr(input string tag, input logic rd, input logic wr,
                             input logic mtr, input logic rw, input logic [4:0] dst,
                             input logic [31:0] alu, input logic [31:0] wd,
                             input int lat, input logic [31:0] rdata);
        logic is_op;
        int   wait_cycles;
        is_op       = rd | wr;
        wait_cycles = is_op ? lat : 0;
        MEM_MemRead = rd;  MEM_MemWrite = wr;  MEM_MemtoReg = mtr;
        MEM_RegWrite = rw; MEM_RegDst = dst;   MEM_ALUResult = alu;
        MEM_ReadData2 = wd;
        for (int c = 0; c <= wait_cycles; c++) begin
            dmem_ack   = is_op && (c == wait_cycles);
            dmem_rdata = (c == wait_cycles) ? rdata : $urandom;
            #4;
            check({tag, ".req"},   {31'b0, dmem_req},  {31'b0, is_op});
            check({tag, ".we"},    {31'b0, dmem_we},   {31'b0, wr && !rd});
            check({tag, ".addr"},  dmem_addr,  alu);
            check({tag, ".wdata"}, dmem_wdata, wd);
            check({tag, ".stall"}, {31'b0, MEM_Stall}, {31'b0, c < wait_cycles});
            check({tag, ".err"},   {31'b0, dmem_err},  32'b0);
            @(posedge clk); #1;
            if (c < wait_cycles) check_wb({tag, ".bubble"}, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        end
        dmem_ack = 1'b0;
        check_wb({tag, ".wb"}, rw, mtr, dst, (is_op && rd) ? rdata : 32'h0, alu);
    endtask

    initial begin
        rst = 1'b1;
        MEM_MemRead = 0; MEM_MemWrite = 0; MEM_MemtoReg = 0; MEM_RegWrite = 0;
        MEM_RegDst = 0; MEM_ALUResult = 0; MEM_ReadData2 = 0;
        dmem_ack = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check_wb("reset", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        check("reset.err", {31'b0, dmem_err}, 32'b0);
        MEM_MemRead = 1'b1;
        #1;
        check("reset.req_forced", {31'b0, dmem_req}, 32'b0);
        check("reset.stall_forced", {31'b0, MEM_Stall}, 32'b0);
        rst = 1'b0;
        MEM_MemRead = 1'b0;

        run_instr("alu",   1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h1234, 32'h0, 0, 32'h0);
        run_instr("ld0",   1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h40, 32'h0, 0, 32'hDEADBEEF);
        run_instr("st3",   1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h80, 32'hA5A5A5A5, 3, 32'h0);
        run_instr("rdwr",  1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 32'hC0, 32'h11111111, 1, 32'hCAFEF00D);

        // Reset arrives in the second WAIT cycle of a load; the simultaneous ack is ignored.
        MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_RegWrite = 1'b1; MEM_MemtoReg = 1'b1;
        MEM_RegDst = 5'd7; MEM_ALUResult = 32'h100; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midwait.stall_before", {31'b0, MEM_Stall}, 32'b1);
        rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h5555AAAA;
        #1;
        check("midwait.req", {31'b0, dmem_req}, 32'b0);
        check("midwait.stall", {31'b0, MEM_Stall}, 32'b0);
        @(posedge clk); #1;
        check_wb("midwait.wb", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        rst = 1'b0; dmem_ack = 1'b0; MEM_MemRead = 1'b0;
        run_instr("after_rst", 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h44, 32'h0, 2, 32'h0BADF00D);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] kind;
            kind = 2'($urandom_range(0, 3));
            run_instr("rnd", kind[0], kind[1], 1'($urandom), 1'($urandom), 5'($urandom),
                      $urandom, $urandom, $urandom_range(0, 3), $urandom);
        end

`ifdef DMEM_TIMEOUT_EN
        MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_RegWrite = 1'b1; MEM_MemtoReg = 1'b1;
        MEM_RegDst = 5'd2; MEM_ALUResult = 32'h200; dmem_ack = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            #4;
            check("tmo.stall", {31'b0, MEM_Stall}, {31'b0, c < 4});
            @(posedge clk); #1;
            check_wb("tmo.bubble", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        end
        check("tmo.err_set", {31'b0, dmem_err}, 32'b1);
        MEM_MemRead = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("tmo.err_sticky", {31'b0, dmem_err}, 32'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("tmo.err_cleared", {31'b0, dmem_err}, 32'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
